// File: rtl/seq_frame_pkg.sv
// Shared definitions for the 1101-sync serial framer and its companion detector bench.
// Optional parity state is present only when SEQ_FRAME_TX_PARITY_EN is defined.
package seq_frame_pkg;

    localparam logic [3:0]  SYNC_PATTERN = 4'b1101;
    localparam int unsigned SYNC_LEN     = 4;
    localparam int unsigned DATA_LEN     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
`ifdef SEQ_FRAME_TX_PARITY_EN
        ST_PAR,
`endif
        ST_GAP
    } tx_state_e;

`ifdef SEQ_FRAME_TX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

endpackage

// File: rtl/seq_frame_tx_if.sv
// Byte-offer handshake between a payload source and the serial framer.
interface seq_frame_tx_if;

    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/seq_frame_tx.sv
// Serial framer: sync 1101, payload MSB first, optional even parity, then an idle gap.
// Define SEQ_FRAME_TX_PARITY_EN for 13-bit frames with a trailing parity bit.
module seq_frame_tx
    import seq_frame_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 2,
    parameter logic        IDLE_BIT   = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    seq_frame_tx_if.slave  tx,
    output logic           dout,
    output logic           dout_en,
    output logic           busy,
    output logic           frame_done
);

    localparam int unsigned GAP_W = (GAP_CYCLES <= 1) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [1:0]       SYNC_LAST   = 2'(SYNC_LEN - 1);
    localparam logic [2:0]       DATA_LAST   = 3'(DATA_LEN - 1);
    localparam logic [2:0]       DATA_PENULT = 3'(DATA_LEN - 2);

    tx_state_e        state_q;
    logic [1:0]       sync_cnt_q, sync_cnt_d;
    logic [2:0]       data_cnt_q, data_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q,  gap_cnt_d;
    logic [7:0]       shift_q;
    logic             dout_q, dout_en_q, done_q;
`ifdef SEQ_FRAME_TX_PARITY_EN
    logic             par_q;
`endif

    assign sync_cnt_d = sync_cnt_q + 2'd1;
    assign data_cnt_d = data_cnt_q + 3'd1;
    assign gap_cnt_d  = gap_cnt_q + GAP_W'(1);

    assign tx.tx_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign dout        = dout_q;
    assign dout_en     = dout_en_q;
    assign frame_done  = done_q;

    // Outputs are loaded with the bit that the *next* state presents, so the
    // registered dout always lines up with state_q and its counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sync_cnt_q <= '0;
            data_cnt_q <= '0;
            gap_cnt_q  <= '0;
            shift_q    <= '0;
            dout_q     <= IDLE_BIT;
            dout_en_q  <= 1'b0;
            done_q     <= 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (tx.tx_valid) begin
                        state_q    <= ST_SYNC;
                        sync_cnt_q <= '0;
                        shift_q    <= tx.tx_data;
`ifdef SEQ_FRAME_TX_PARITY_EN
                        par_q      <= even_parity(tx.tx_data);
`endif
                        dout_q     <= SYNC_PATTERN[2'(SYNC_LEN - 1)];
                        dout_en_q  <= 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (sync_cnt_q == SYNC_LAST) begin
                        state_q    <= ST_DATA;
                        data_cnt_q <= '0;
                        dout_q     <= shift_q[7];
                        shift_q    <= {shift_q[6:0], 1'b0};
                    end else begin
                        sync_cnt_q <= sync_cnt_d;
                        dout_q     <= SYNC_PATTERN[~sync_cnt_d];
                    end
                end
                ST_DATA: begin
                    if (data_cnt_q == DATA_LAST) begin
`ifdef SEQ_FRAME_TX_PARITY_EN
                        state_q <= ST_PAR;
                        dout_q  <= par_q;
                        done_q  <= 1'b1;
`else
                        state_q   <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                        gap_cnt_q <= '0;
                        dout_q    <= IDLE_BIT;
                        dout_en_q <= 1'b0;
`endif
                    end else begin
                        data_cnt_q <= data_cnt_d;
                        dout_q     <= shift_q[7];
                        shift_q    <= {shift_q[6:0], 1'b0};
`ifndef SEQ_FRAME_TX_PARITY_EN
                        if (data_cnt_q == DATA_PENULT) done_q <= 1'b1;
`endif
                    end
                end
`ifdef SEQ_FRAME_TX_PARITY_EN
                ST_PAR: begin
                    state_q   <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    gap_cnt_q <= '0;
                    dout_q    <= IDLE_BIT;
                    dout_en_q <= 1'b0;
                end
`endif
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_d;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    dout_q    <= IDLE_BIT;
                    dout_en_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Scoreboard bench for seq_frame_tx: stimulus pushes hand-computed frames, a monitor checks dout.
// Honours SEQ_FRAME_TX_PARITY_EN the same way as the RTL.
module tb_seq_frame_tx;

    localparam logic IDLE = 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
    localparam int FLEN = 13;
`else
    localparam int FLEN = 12;
`endif

    typedef struct {
        logic [12:0] bits;
        logic [12:0] det;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic dout, dout_en, busy, frame_done;
    logic dout0, dout_en0, busy0, frame_done0;

    seq_frame_tx_if txif ();
    seq_frame_tx_if txif0 ();

    seq_frame_tx #(.GAP_CYCLES(2), .IDLE_BIT(1'b0)) u_dut (
        .clk(clk), .reset(reset), .tx(txif),
        .dout(dout), .dout_en(dout_en), .busy(busy), .frame_done(frame_done)
    );

    seq_frame_tx #(.GAP_CYCLES(0), .IDLE_BIT(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .tx(txif0),
        .dout(dout0), .dout_en(dout_en0), .busy(busy0), .frame_done(frame_done0)
    );

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   frames_seen = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [11:0] f, input logic p, input logic [12:0] det);
        exp_t e;
`ifdef SEQ_FRAME_TX_PARITY_EN
        e.bits = {f, p};
`else
        e.bits = {1'b0, f};
`endif
        e.det = det;
        return e;
    endfunction

    // Monitor: assembles frames from dout and runs an overlapping 1101 Mealy detector on it.
    initial begin
        int          nb, dcnt, dat;
        logic [12:0] got, dg;
        logic        in_f, det;
        logic [1:0]  dst;
        exp_t        cur;
        in_f = 1'b0; dst = 2'd0; nb = 0; dcnt = 0; dat = -1; got = '0; dg = '0;
        cur = '{bits: '0, det: '0};
        forever begin
            @(negedge clk);
            if (reset) begin
                in_f = 1'b0;
                dst  = 2'd0;
                continue;
            end
            det = (dst == 2'd3) && dout;
            case (dst)
                2'd0:    dst = dout ? 2'd1 : 2'd0;
                2'd1:    dst = dout ? 2'd2 : 2'd0;
                2'd2:    dst = dout ? 2'd2 : 2'd3;
                default: dst = dout ? 2'd1 : 2'd0;
            endcase
            if (dout_en) begin
                if (!in_f) begin
                    check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                    if (sb_q.size() != 0) cur = sb_q.pop_front();
                    else cur = '{bits: '0, det: '0};
                    in_f = 1'b1; nb = 0; got = '0; dg = '0; dcnt = 0; dat = -1;
                end
                got = {got[11:0], dout};
                if (det) dg[nb] = 1'b1;
                if (frame_done) begin
                    dcnt++;
                    dat = nb;
                end
                nb++;
                if (nb == FLEN) begin
                    check("frame_bits", 32'(got), 32'(cur.bits));
                    check("frame_done_pos", 32'(dcnt == 1 && dat == FLEN - 1), 32'd1);
                    check("detect_mask", 32'(dg), 32'(cur.det));
                    frames_seen++;
                    in_f = 1'b0;
                end
            end else begin
                if (in_f) begin
                    check("frame_truncated", 32'(nb), 32'(FLEN));
                    in_f = 1'b0;
                end
                check("idle_level", 32'({dout, frame_done}), 32'({IDLE, 1'b0}));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input exp_t e);
        int n;
        n = 0;
        @(negedge clk);
        while (!txif.tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!txif.tx_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        txif.tx_valid = 1'b1;
        txif.tx_data  = b;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        txif.tx_valid = 1'b0;
        txif.tx_data  = ~b;
        check("first_sync_bit", 32'({dout_en, dout, busy, txif.tx_ready}), 32'(4'b1110));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!frame_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("frame_done_seen", 32'(frame_done), 32'd1);
    endtask

    initial begin
        logic [27:0] en_s, bit_s, rdy_s;
        logic [12:0] f1, f2;
        int          n1, n2, n;
        exp_t        e11, e22;

        txif.tx_valid  = 1'b0;
        txif.tx_data   = '0;
        txif0.tx_valid = 1'b0;
        txif0.tx_data  = '0;

        repeat (3) @(negedge clk);
        check("reset_state", 32'({dout, dout_en, busy, frame_done, txif.tx_ready}), 32'(5'b00001));
        @(posedge clk);
        #2 reset = 1'b0;

        send_byte(8'hA5, mk(12'b1101_1010_0101, 1'b0, 13'h0048));
        wait_done();
        @(negedge clk);
        check("gap_cycle1", 32'({dout_en, busy, txif.tx_ready}), 32'(3'b010));
        @(negedge clk);
        check("gap_cycle2", 32'({dout_en, busy, txif.tx_ready}), 32'(3'b010));
        @(negedge clk);
        check("idle_after_gap", 32'({dout_en, busy, txif.tx_ready}), 32'(3'b001));

        send_byte(8'h00, mk(12'b1101_0000_0000, 1'b0, 13'h0008));
        send_byte(8'hD0, mk(12'b1101_1101_0000, 1'b1, 13'h0088));
        send_byte(8'hFF, mk(12'b1101_1111_1111, 1'b0, 13'h0008));
        send_byte(8'h3C, mk(12'b1101_0011_1100, 1'b0, 13'h0008));
        send_byte(8'h07, mk(12'b1101_0000_0111, 1'b1, 13'h0008));
        send_byte(8'h03, mk(12'b1101_0000_0011, 1'b0, 13'h0008));

        // Abort during payload bit 3 (frame bit 8), then resend.
        send_byte(8'h3C, mk(12'b1101_0011_1100, 1'b0, 13'h0008));
        repeat (8) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("reset_abort", 32'({dout, dout_en, busy, frame_done, txif.tx_ready}), 32'(5'b00001));
        @(posedge clk);
        #2 reset = 1'b0;
        send_byte(8'hFF, mk(12'b1101_1111_1111, 1'b0, 13'h0008));

        n = 0;
        while (frames_seen < 8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("frames_completed", 32'(frames_seen), 32'd8);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        // Back-to-back frames with tx_valid held and no gap.
        e11 = mk(12'b1101_0001_0001, 1'b0, 13'h0);
        e22 = mk(12'b1101_0010_0010, 1'b0, 13'h0);
        en_s = '0; bit_s = '0; rdy_s = '0;
        @(negedge clk);
        txif0.tx_valid = 1'b1;
        txif0.tx_data  = 8'h11;
        @(posedge clk);
        for (int i = 0; i < 2 * FLEN + 2; i++) begin
            @(negedge clk);
            en_s[i]  = dout_en0;
            bit_s[i] = dout0;
            rdy_s[i] = txif0.tx_ready;
            if (i == 0) txif0.tx_data = 8'h22;
        end
        txif0.tx_valid = 1'b0;
        f1 = '0; f2 = '0; n1 = 0; n2 = 0;
        for (int i = 0; i < FLEN; i++) begin
            f1 = {f1[11:0], bit_s[i]};
            f2 = {f2[11:0], bit_s[FLEN + 1 + i]};
            n1 += int'(en_s[i]);
            n2 += int'(en_s[FLEN + 1 + i]);
        end
        check("b2b_frame1", 32'(f1), 32'(e11.bits));
        check("b2b_frame2", 32'(f2), 32'(e22.bits));
        check("b2b_en1", 32'(n1), 32'(FLEN));
        check("b2b_en2", 32'(n2), 32'(FLEN));
        check("b2b_idle_slots",
              32'({en_s[FLEN], rdy_s[FLEN], en_s[2*FLEN+1], rdy_s[2*FLEN+1]}), 32'(4'b0101));

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
